// File: rtl/id_ex_stage.sv
// ID/EX stage: immediate generation, write-back bypass, load-use detect, E register.
// Latency: 1 cycle D->E; LoadStallD is combinational from E state and D inputs.
// Backpressure: LoadStallD holds upstream for one cycle while a bubble enters E; FlushE kills the entry.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               InstrD,
    input  logic [DATA_WIDTH-1:0]     PCD,
    input  logic [DATA_WIDTH-1:0]     PCPlus4D,
    input  logic                      ValidD,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic                      RegWriteW,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic [DATA_WIDTH-1:0]     ResultW,
    input  logic                      FlushE,
    output logic                      LoadStallD,
    output logic                      ValidE,
    output logic [DATA_WIDTH-1:0]     RD1E,
    output logic [DATA_WIDTH-1:0]     RD2E,
    output logic [DATA_WIDTH-1:0]     ImmExtE,
    output logic [REG_ADDR_WIDTH-1:0] Rs1E,
    output logic [REG_ADDR_WIDTH-1:0] Rs2E,
    output logic [REG_ADDR_WIDTH-1:0] RdE,
    output logic [DATA_WIDTH-1:0]     PCE,
    output logic [DATA_WIDTH-1:0]     PCPlus4E,
    output logic [6:0]                OpcodeE,
    output logic [2:0]                Funct3E,
    output logic                      Funct7b5E
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     rd1;
        logic [DATA_WIDTH-1:0]     rd2;
        logic [DATA_WIDTH-1:0]     imm;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     pcp4;
        logic [6:0]                opcode;
        logic [2:0]                funct3;
        logic                      funct7b5;
    } ex_t;

    ex_t e_q, e_nxt;

    logic [REG_ADDR_WIDTH-1:0] rs1_d, rs2_d, rd_d;
    logic [6:0]                op_d;
    logic [31:0]               imm_d;
    logic [DATA_WIDTH-1:0]     src1_d, src2_d;

    assign rs1_d = InstrD[19:15];
    assign rs2_d = InstrD[24:20];
    assign rd_d  = InstrD[11:7];
    assign op_d  = InstrD[6:0];

    always_comb begin
        imm_d = '0;
        case (op_d)
            OP_LOAD, OP_OPIMM, OP_JALR: imm_d = {{20{InstrD[31]}}, InstrD[31:20]};
            OP_STORE:                   imm_d = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            OP_BRANCH:                  imm_d = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                                                 InstrD[30:25], InstrD[11:8], 1'b0};
            OP_LUI, OP_AUIPC:           imm_d = {InstrD[31:12], 12'b0};
            OP_JAL:                     imm_d = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12],
                                                 InstrD[20], InstrD[30:21], 1'b0};
            default:                    imm_d = '0;
        endcase
    end

    // Register-file writes land at the edge, so forward the W result into this cycle's read.
    assign src1_d = (RegWriteW && RdW != '0 && RdW == rs1_d) ? ResultW : RD1D;
    assign src2_d = (RegWriteW && RdW != '0 && RdW == rs2_d) ? ResultW : RD2D;

    // rs2 is compared even for formats without rs2: conservative, never misses a hazard.
    assign LoadStallD = e_q.valid && ValidD && (e_q.opcode == OP_LOAD) && (e_q.rd != '0) &&
                        ((e_q.rd == rs1_d) || (e_q.rd == rs2_d));

    always_comb begin
        e_nxt = '0;
        if (!FlushE && !LoadStallD) begin
            e_nxt.valid    = ValidD;
            e_nxt.rd1      = src1_d;
            e_nxt.rd2      = src2_d;
            e_nxt.imm      = imm_d;
            e_nxt.rs1      = rs1_d;
            e_nxt.rs2      = rs2_d;
            e_nxt.rd       = ValidD ? rd_d : '0;
            e_nxt.pc       = PCD;
            e_nxt.pcp4     = PCPlus4D;
            e_nxt.opcode   = op_d;
            e_nxt.funct3   = InstrD[14:12];
            e_nxt.funct7b5 = InstrD[30];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) e_q <= '0;
        else      e_q <= e_nxt;
    end

    assign ValidE    = e_q.valid;
    assign RD1E      = e_q.rd1;
    assign RD2E      = e_q.rd2;
    assign ImmExtE   = e_q.imm;
    assign Rs1E      = e_q.rs1;
    assign Rs2E      = e_q.rs2;
    assign RdE       = e_q.rd;
    assign PCE       = e_q.pc;
    assign PCPlus4E  = e_q.pcp4;
    assign OpcodeE   = e_q.opcode;
    assign Funct3E   = e_q.funct3;
    assign Funct7b5E = e_q.funct7b5;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed pins plus randomized traffic against a behavioural model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, RD1D, RD2D, ResultW;
    logic        ValidD, RegWriteW, FlushE;
    logic [4:0]  RdW;
    logic        LoadStallD, ValidE, Funct7b5E;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [6:0]  OpcodeE;
    logic [2:0]  Funct3E;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .RD1D(RD1D), .RD2D(RD2D), .RegWriteW(RegWriteW), .RdW(RdW),
        .ResultW(ResultW), .FlushE(FlushE), .LoadStallD(LoadStallD), .ValidE(ValidE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .OpcodeE(OpcodeE), .Funct3E(Funct3E),
        .Funct7b5E(Funct7b5E)
    );

    // Expected E-stage contents, kept as plain variables
    logic        m_v, m_f7;
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_pcp4;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [6:0]  m_op;
    logic [2:0]  m_f3;

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic [31:0] r;
        r = v & ((32'd1 << bits) - 32'd1);
        if (r[bits-1]) r = r | ~((32'd1 << bits) - 32'd1);
        return r;
    endfunction

    // Immediate rebuilt from the field definitions as a number, not bit slices of a case table
    function automatic logic [31:0] imm_of(input logic [31:0] i);
        logic [31:0] v;
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: v = sext(i >> 20, 12);
            7'b0100011: v = sext(((i >> 25) << 5) | ((i >> 7) & 32'h1F), 12);
            7'b1100011: v = sext((((i >> 31) & 1) << 12) | (((i >> 7) & 1) << 11) |
                                 (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1), 13);
            7'b0110111, 7'b0010111: v = i & 32'hFFFFF000;
            7'b1101111: v = sext((((i >> 31) & 1) << 20) | (((i >> 12) & 32'hFF) << 12) |
                                 (((i >> 20) & 1) << 11) | (((i >> 21) & 32'h3FF) << 1), 21);
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
        return (RegWriteW && RdW != 0 && RdW == idx) ? ResultW : rf;
    endfunction

    function automatic logic model_stall();
        logic [4:0] a, b;
        a = InstrD[19:15];
        b = InstrD[24:20];
        return m_v && ValidD && m_op == 7'd3 && m_rd != 0 && (m_rd == a || m_rd == b);
    endfunction

    task automatic model_clear();
        m_v = 0; m_f7 = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0; m_pcp4 = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 0; m_f3 = 0;
    endtask

    task automatic model_edge();
        if (!rst || FlushE || model_stall()) begin
            model_clear();
        end else begin
            m_v    = ValidD;
            m_rd1  = fwd(InstrD[19:15], RD1D);
            m_rd2  = fwd(InstrD[24:20], RD2D);
            m_imm  = imm_of(InstrD);
            m_rs1  = InstrD[19:15];
            m_rs2  = InstrD[24:20];
            m_rd   = ValidD ? InstrD[11:7] : 5'd0;
            m_pc   = PCD;
            m_pcp4 = PCPlus4D;
            m_op   = InstrD[6:0];
            m_f3   = InstrD[14:12];
            m_f7   = InstrD[30];
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_e();
        chk("ValidE", {31'd0, ValidE}, {31'd0, m_v});
        chk("RD1E", RD1E, m_rd1);
        chk("RD2E", RD2E, m_rd2);
        chk("ImmExtE", ImmExtE, m_imm);
        chk("Rs1E", {27'd0, Rs1E}, {27'd0, m_rs1});
        chk("Rs2E", {27'd0, Rs2E}, {27'd0, m_rs2});
        chk("RdE", {27'd0, RdE}, {27'd0, m_rd});
        chk("PCE", PCE, m_pc);
        chk("PCPlus4E", PCPlus4E, m_pcp4);
        chk("OpcodeE", {25'd0, OpcodeE}, {25'd0, m_op});
        chk("Funct3E", {29'd0, Funct3E}, {29'd0, m_f3});
        chk("Funct7b5E", {31'd0, Funct7b5E}, {31'd0, m_f7});
    endtask

    task automatic check_stall();
        chk("LoadStallD", {31'd0, LoadStallD}, {31'd0, model_stall()});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_e();
    endtask

    task automatic drive(input logic [31:0] instr, input logic vld, input logic [31:0] r1,
                         input logic [31:0] r2, input logic rw, input logic [4:0] rdw,
                         input logic [31:0] res, input logic fl);
        InstrD = instr; ValidD = vld; RD1D = r1; RD2D = r2;
        RegWriteW = rw; RdW = rdw; ResultW = res; FlushE = fl;
        PCD = $urandom & 32'hFFFFFFFC; PCPlus4D = PCD + 4;
        #1 check_stall();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam logic [6:0] OPS [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63,
                                        7'h37, 7'h17, 7'h6F, 7'h33, 7'h0B};

    initial begin
        logic [31:0] ins;
        rst = 0;
        model_clear();
        InstrD = 0; ValidD = 0; RD1D = 0; RD2D = 0; RegWriteW = 0; RdW = 0;
        ResultW = 0; FlushE = 0; PCD = 0; PCPlus4D = 0;
        @(negedge clk);
        compare_e();
        check_stall();
        rst = 1;

        // addi x1,x2,-4
        drive(32'hFFC10093, 1, 32'h0, 32'h0, 0, 0, 0, 0);
        step();
        chk("imm_addi", ImmExtE, 32'hFFFFFFFC);
        chk("rs1_addi", {27'd0, Rs1E}, 32'd2);
        chk("rd_addi", {27'd0, RdE}, 32'd1);
        chk("op_addi", {25'd0, OpcodeE}, 32'h13);
        chk("valid_addi", {31'd0, ValidE}, 32'd1);

        // write-through bypass on rs1 = x5, then x0 never bypassed
        drive(32'h00028093, 1, 32'h11111111, 32'h0, 1, 5'd5, 32'hDEADBEEF, 0);
        step();
        chk("bypass_x5", RD1E, 32'hDEADBEEF);
        drive(32'h00000093, 1, 32'h0, 32'h0, 1, 5'd0, 32'hDEADBEEF, 0);
        step();
        chk("bypass_x0", RD1E, 32'h0);

        // load-use: lw x3,0(x4) then add x5,x3,x6
        drive(32'h00022183, 1, 32'h100, 32'h0, 0, 0, 0, 0);
        step();
        drive(32'h006182B3, 1, 32'h7, 32'h9, 0, 0, 0, 0);
        chk("stall_lu", {31'd0, LoadStallD}, 32'd1);
        step();
        chk("bubble_valid", {31'd0, ValidE}, 32'd0);
        chk("bubble_rd", {27'd0, RdE}, 32'd0);
        chk("stall_clear", {31'd0, LoadStallD}, 32'd0);
        step();
        chk("held_rd", {27'd0, RdE}, 32'd5);
        chk("held_rs1", {27'd0, Rs1E}, 32'd3);

        // lw x0 followed by a user of x0
        drive(32'h00022003, 1, 32'h0, 32'h0, 0, 0, 0, 0);
        step();
        drive(32'h000002B3, 1, 32'h0, 32'h0, 0, 0, 0, 0);
        chk("stall_x0", {31'd0, LoadStallD}, 32'd0);
        step();
        chk("x0_nobubble", {31'd0, ValidE}, 32'd1);

        // flush coinciding with a load-use hazard
        drive(32'h00022183, 1, 32'h0, 32'h0, 0, 0, 0, 0);
        step();
        drive(32'h006182B3, 1, 32'h5, 32'h6, 0, 0, 0, 1);
        chk("stall_flush", {31'd0, LoadStallD}, 32'd1);
        step();
        chk("flush_valid", {31'd0, ValidE}, 32'd0);
        chk("flush_pc", PCE, 32'd0);
        chk("flush_op", {25'd0, OpcodeE}, 32'd0);

        // asynchronous reset mid-operation
        drive(32'h00022183, 1, 32'h55, 32'h66, 0, 0, 0, 0);
        step();
        drive(32'h006182B3, 1, 32'h1, 32'h2, 0, 0, 0, 0);
        rst = 0;
        model_clear();
        #1;
        compare_e();
        check_stall();
        chk("rst_pc", PCE, 32'd0);
        step();
        rst = 1;
        #1 check_stall();
        step();
        chk("post_rst_rd", {27'd0, RdE}, 32'd5);

        // randomized traffic; a stalled instruction is held in D as upstream would do
        for (int n = 0; n < 3000; n++) begin
            if (!model_stall()) begin
                ins = $urandom;
                ins[6:0]   = OPS[$urandom_range(0, 9)];
                ins[11:7]  = 5'($urandom_range(0, 7));
                ins[19:15] = 5'($urandom_range(0, 7));
                ins[24:20] = 5'($urandom_range(0, 7));
            end else begin
                ins = InstrD;
            end
            drive(ins, $urandom_range(0, 7) != 0, $urandom, $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 7) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute stage of the pipelined RV32I core. It sits directly downstream of the register file. It takes the fetched instruction plus RD1/RD2 from the register file and performs three jobs:
- generates the sign-extended immediate;
- applies write-back write-through bypass, because a register-file write lands at the clock edge while reads are combinational;
- registers everything into the ID/EX pipeline register.

It also detects load-use hazards and inserts bubbles. It honours a branch flush from EX.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low; clears all E-stage state.
- InstrD  input  32  instruction in decode.
- PCD  input  32  PC of InstrD.
- PCPlus4D  input  32  PC+4 of InstrD.
- ValidD  input  1  InstrD is a real instruction.
- RD1D  input  32  register file read data for rs1 = InstrD[19:15].
- RD2D  input  32  register file read data for rs2 = InstrD[24:20].
- RegWriteW  input  1  write-back stage writes the register file this cycle.
- RdW  input  5  write-back destination.
- ResultW  input  32  write-back data.
- FlushE  input  1  branch/jump taken in EX; kill the instruction entering E.
- LoadStallD  output  1  combinational; holds PC and IF/ID upstream this cycle.
- ValidE  output  1  E-stage instruction valid.
- RD1E, RD2E  output  32 each  bypassed operands.
- ImmExtE  output  32  sign-extended immediate.
- Rs1E, Rs2E, RdE  output  5 each  register indices.
- PCE, PCPlus4E  output  32 each.
- OpcodeE  output  7  instruction opcode.
- Funct3E  output  3  instruction funct3.
- Funct7b5E  output  1  InstrE[30].

## Operation
Field extraction:
- rs1D = InstrD[19:15], rs2D = InstrD[24:20], rdD = InstrD[11:7].

Immediate generation, selected by InstrD[6:0]:
- I-type (0000011, 0010011, 1100111): {20{i[31]}, i[31:20]}.
- S-type (0100011): {20{i[31]}, i[31:25], i[11:7]}.
- B-type (1100011): {19{i[31]}, i[31], i[7], i[30:25], i[11:8], 1'b0}.
- U-type (0110111, 0010111): {i[31:12], 12'b0}.
- J-type (1101111): {11{i[31]}, i[31], i[19:12], i[20], i[30:21], 1'b0}.
- Any other opcode: 0.

Write-through bypass:
- src1 = ResultW when RegWriteW and RdW != 0 and RdW == rs1D; otherwise RD1D.
- src2 is formed the same way, using rs2D and RD2D.
- A write to x0 is never bypassed.

Load-use detect:
- LoadStallD = ValidE & ValidD & (OpcodeE == 0000011) & (RdE != 0) & (RdE == rs1D | RdE == rs2D).
- rs2D is compared for every instruction type. This is a deliberate, conservative choice.

Next-state of the E register, in priority order:
1. FlushE = 1: load a bubble.
2. LoadStallD = 1: load a bubble. InstrD stays in D, held upstream.
3. Otherwise: load the D-stage values, with ValidE = ValidD.

Bubble definition:
- Every E output is 0, including ValidE, RdE, OpcodeE and ImmExtE.
- A bubble therefore never writes a register and never re-triggers a stall.

ValidD = 0 with no flush or stall:
- Fields are still registered, but ValidE = 0.
- RdE is forced to 0.

## Timing
- Reset: while rst = 0, every E output is 0 immediately (asynchronous), and LoadStallD = 0. State is first updated on the first rising edge after rst returns to 1.
- Reset asserted mid-operation discards the in-flight E instruction. No partial update occurs.
- Latency: D to E is 1 cycle. All E outputs are registered.
- LoadStallD is combinational from registered E state and the current D inputs. It is valid in the same cycle.
- Stall length: exactly 1 cycle per load-use pair. After the bubble, ValidE = 0, so the stall clears and the held instruction enters E on the following edge.
- FlushE together with LoadStallD in the same cycle: a bubble is loaded, and LoadStallD still asserts. Upstream flush logic takes precedence there.
- Bypass is evaluated in the same cycle as the register-file write. A W-stage write and a D-stage read of the same register in one cycle therefore yield the new value in RD1E/RD2E.

## Test plan
- Reset: drive valid traffic, then pull rst low between edges. Required: all E outputs 0 and LoadStallD = 0 before the next edge. After release, the first edge registers the D inputs.
- Immediate: InstrD = 0xFFC10093 (addi x1,x2,-4), ValidD = 1. Required after one edge: ImmExtE = 0xFFFFFFFC, Rs1E = 2, RdE = 1, OpcodeE = 0010011, ValidE = 1.
- Bypass: rs1D = 5, RD1D = 0x11111111, RegWriteW = 1, RdW = 5, ResultW = 0xDEADBEEF. Required: RD1E = 0xDEADBEEF. Repeat with rs1D = 0, RdW = 0, RD1D = 0. Required: RD1E = 0.
- Load-use: E holds 0x00022183 (lw x3,0(x4)); D = 0x006182B3 (add x5,x3,x6), ValidD = 1. Required: LoadStallD = 1 that cycle. Next edge: ValidE = 0 and RdE = 0, with LoadStallD = 0. The edge after that: RdE = 5 and Rs1E = 3.
- Load to x0: E holds lw x0 and D uses x0. Required: LoadStallD = 0 and no bubble.
- Flush: FlushE = 1 with a valid add in D, in the same cycle as a load-use condition. Required: bubble in E (ValidE = 0, all outputs 0) on the next edge.
